sync_memory_ctrl: RTL and testbench

SYNC_MEMORY_CTRL -- requirements
Module: sync_memory_ctrl

---
 rtl/sync_memory_ctrl.sv | 103 ++++++++++
 tb/tb_sync_memory_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory_ctrl.sv
// rtl/sync_memory_ctrl.sv - single-port word memory with sweep clear, 1-cycle reads and error pulses
module sync_memory_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read,
  input  logic             write,
  input  logic             clear,
  input  logic [AW-1:0]    adr,
  input  logic [WIDTH-1:0] wdata,
  output logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             adr_ok;
  logic             sweep_last;
  logic             rd_acc;
  logic             wr_acc;
  logic             req_err;

  // Non-power-of-two depths leave addresses that decode to no word.
  assign adr_ok     = (int'(adr) < DEPTH);
  assign sweep_last = (int'(cnt) == DEPTH - 1);

  // State and sweep counter register; reset restarts the sweep at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and request decode; clear wins over any access in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    req_err   = 1'b0;
    if (state == CLEAR) begin
      if (sweep_last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      ready = 1'b1;
      if (clear) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end else if (read && write) begin
        req_err = 1'b1;
      end else if (read || write) begin
        if (!adr_ok) begin
          req_err = 1'b1;
        end else begin
          rd_acc = read;
          wr_acc = write;
        end
      end
    end
  end

  // Storage array: sweep writes zeros, otherwise accepted writes land here.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      mem[adr] <= wdata;
    end
  end

  // Registered read data and response pulses; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      err    <= req_err;
      if (rd_acc) begin
        rdata <= mem[adr];
      end
    end
  end

endmodule

// File: tb/tb_sync_memory_ctrl.sv
// tb/tb_sync_memory_ctrl.sv - scoreboard bench for sync_memory_ctrl (8x8 and 6x16 instances)
module tb_sync_memory_ctrl;

  localparam int NI = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        read  = 1'b0;
  logic        write = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  adr   = '0;
  logic [15:0] wdata = '0;

  logic        ready_a, rvalid_a, err_a;
  logic [7:0]  rdata_a;
  logic        ready_b, rvalid_b, err_b;
  logic [15:0] rdata_b;

  always #5 clk = ~clk;

  sync_memory_ctrl #(.WIDTH(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .clear(clear),
    .adr(adr), .wdata(wdata[7:0]), .ready(ready_a), .rdata(rdata_a),
    .rvalid(rvalid_a), .err(err_a)
  );

  sync_memory_ctrl #(.WIDTH(16), .DEPTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .clear(clear),
    .adr(adr), .wdata(wdata), .ready(ready_b), .rdata(rdata_b),
    .rvalid(rvalid_b), .err(err_b)
  );

  typedef struct packed {
    logic        is_err;
    logic [15:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          depth[NI] = '{8, 6};
  logic [15:0] mask[NI]  = '{16'h00ff, 16'hffff};
  logic [15:0] model_mem[NI][8];
  int          clr_left[NI];
  logic [15:0] last_a = '0;
  logic [15:0] last_b = '0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int i, input logic is_err, input logic [15:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    if (i == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Reference behaviour: a sweeping instance ignores everything; otherwise clear, error, write, read.
  task automatic model_step(input int i);
    if (clr_left[i] != 0) begin
      clr_left[i]--;
    end else if (clear) begin
      clr_left[i] = depth[i];
      for (int k = 0; k < 8; k++) model_mem[i][k] = '0;
    end else if (read && write) begin
      push(i, 1'b1, 16'h0);
    end else if ((read || write) && int'(adr) >= depth[i]) begin
      push(i, 1'b1, 16'h0);
    end else if (write) begin
      model_mem[i][adr] = wdata & mask[i];
    end else if (read) begin
      push(i, 1'b0, model_mem[i][adr]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      clr_left[i] = depth[i];
      for (int k = 0; k < 8; k++) model_mem[i][k] = '0;
    end
  endtask

  // Called on a falling edge; drives one cycle of stimulus and returns on the next falling edge.
  task automatic step(input logic rd, input logic wr, input logic cl, input logic [2:0] a,
                      input logic [15:0] wd);
    read = rd; write = wr; clear = cl; adr = a; wdata = wd;
    check("ready_a", 16'(ready_a), 16'(clr_left[0] == 0));
    check("ready_b", 16'(ready_b), 16'(clr_left[1] == 0));
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready_a", 16'(ready_a), 16'h0);
    check("rst_rvalid_a", 16'(rvalid_a), 16'h0);
    check("rst_err_a", 16'(err_a), 16'h0);
    check("rst_rdata_a", 16'(rdata_a), 16'h0);
    check("rst_ready_b", 16'(ready_b), 16'h0);
    check("rst_rvalid_b", 16'(rvalid_b), 16'h0);
    check("rst_err_b", 16'(err_b), 16'h0);
    check("rst_rdata_b", rdata_b, 16'h0);
  endtask

  // Presents a request, then pulls reset just after the edge that would have accepted it.
  task automatic reset_pulse(input logic rd, input logic [2:0] a);
    read = rd; write = 1'b0; clear = 1'b0; adr = a;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    read  = 1'b0;
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor for the 8x8 instance.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rvalid_a || err_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected: rvalid=%b err=%b, required no pulse at %0t", rvalid_a, err_a, $time);
      end else begin
        e = q_a.pop_front();
        check("a_err", 16'(err_a), 16'(e.is_err));
        check("a_rvalid", 16'(rvalid_a), 16'(!e.is_err));
        if (!e.is_err) begin
          check("a_rdata", 16'(rdata_a), e.data);
          last_a = e.data;
        end
      end
    end else begin
      check("a_rdata_hold", 16'(rdata_a), last_a);
    end
  end

  // Monitor for the 6x16 instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rvalid_b || err_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: rvalid=%b err=%b, required no pulse at %0t", rvalid_b, err_b, $time);
      end else begin
        e = q_b.pop_front();
        check("b_err", 16'(err_b), 16'(e.is_err));
        check("b_rvalid", 16'(rvalid_b), 16'(!e.is_err));
        if (!e.is_err) begin
          check("b_rdata", rdata_b, e.data);
          last_b = e.data;
        end
      end
    end else begin
      check("b_rdata_hold", rdata_b, last_b);
    end
  end

  initial begin
    int r;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Sweep after reset, then every word reads zero (out-of-range words error on the 6-deep unit).
    repeat (9) step(0, 0, 0, 3'd0, 16'h0);
    for (int a = 0; a < 8; a++) step(1, 0, 0, 3'(a), 16'h0);

    // Back-to-back reads of two fresh writes.
    step(0, 1, 0, 3'd0, 16'h0001);
    step(0, 1, 0, 3'd1, 16'h0002);
    step(1, 0, 0, 3'd0, 16'h0);
    step(1, 0, 0, 3'd1, 16'h0);

    // Read immediately after a write to the same word.
    step(0, 1, 0, 3'd3, 16'h00A5);
    step(1, 0, 0, 3'd3, 16'h0);

    // Simultaneous read and write is rejected and leaves the word alone.
    step(1, 1, 0, 3'd2, 16'h00FF);
    step(1, 0, 0, 3'd2, 16'h0);

    // Address 7 is valid for the 8-deep unit and an error for the 6-deep unit.
    step(0, 1, 0, 3'd7, 16'h1234);
    for (int a = 0; a < 8; a++) step(1, 0, 0, 3'(a), 16'h0);

    // Clear beats a concurrent read; clear held during the sweep must not restart it.
    step(1, 0, 1, 3'd5, 16'h0);
    repeat (8) step(0, 0, 1, 3'd0, 16'h0);
    repeat (9) step(0, 0, 0, 3'd0, 16'h0);
    for (int a = 0; a < 8; a++) step(1, 0, 0, 3'(a), 16'h0);

    // Reset in the middle of a sweep.
    for (int a = 0; a < 6; a++) step(0, 1, 0, 3'(a), 16'($urandom));
    step(0, 0, 1, 3'd0, 16'h0);
    repeat (4) step(0, 0, 0, 3'd0, 16'h0);
    reset_pulse(1'b0, 3'd0);
    repeat (9) step(0, 0, 0, 3'd0, 16'h0);

    // Reset right after a read is accepted suppresses its response.
    for (int a = 0; a < 6; a++) step(0, 1, 0, 3'(a), 16'($urandom));
    reset_pulse(1'b1, 3'd3);
    repeat (9) step(0, 0, 0, 3'd0, 16'h0);
    for (int a = 0; a < 8; a++) step(1, 0, 0, 3'(a), 16'h0);

    // Randomised traffic.
    repeat (400) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       step(0, 0, 1, 3'($urandom_range(0, 7)), 16'($urandom));
      else if (r < 40) step(0, 1, 0, 3'($urandom_range(0, 7)), 16'($urandom));
      else if (r < 85) step(1, 0, 0, 3'($urandom_range(0, 7)), 16'($urandom));
      else if (r < 90) step(1, 1, 0, 3'($urandom_range(0, 7)), 16'($urandom));
      else             step(0, 0, 0, 3'($urandom_range(0, 7)), 16'($urandom));
    end

    repeat (3) step(0, 0, 0, 3'd0, 16'h0);
    check("q_a_drained", 16'(q_a.size()), 16'h0);
    check("q_b_drained", 16'(q_b.size()), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
